lv_owt_tx_arb: RTL and testbench
================================

LV_OWT_TX_ARB -- requirements
Module: lv_owt_tx_arb

Interface
REQ-001 The block SHALL have parameter FRM_W, default 16, meaning OWT frame width in bits.
REQ-002 The block SHALL have parameter TMO_CYC, default 255, meaning cycles in SEND before timeout (8-bit counter).
REQ-003 The block SHALL have parameter RETRY_MAX, default 3, meaning maximum transmissions per grant including the first.
REQ-004 The block SHALL have parameter GAP_CYC, default 4, meaning inter-frame idle cycles (minimum 1).
REQ-005 The block SHALL have port i_clk, input, 1 bit, the single clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port i_rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-007 The block SHALL have port i_en, input, 1 bit, the arbitration enable driven by the control FSM owt_com enable.
REQ-008 The block SHALL have port i_req, input, 3 bits: bit0 = FSM watchdog, bit1 = SPI forward, bit2 = status poll.
REQ-009 The block SHALL have port i_req_frm, input, 3*FRM_W bits, holding the frame of requester k at [k*FRM_W +: FRM_W].
REQ-010 The block SHALL have port o_req_ack, output, 3 bits, a one-cycle pulse per requester on successful transfer.
REQ-011 The block SHALL have port o_req_err, output, 3 bits, a one-cycle pulse per requester when retries are exhausted.
REQ-012 The block SHALL have port o_tx_req, output, 1 bit, a level request to the OWT tx engine.
REQ-013 The block SHALL have port o_tx_frm, output, FRM_W bits, the frame presented to the engine.
REQ-014 The block SHALL have port i_tx_done, input, 1 bit, a one-cycle engine completion pulse.
REQ-015 The block SHALL have port i_tx_nack, input, 1 bit, a failure qualifier valid only with i_tx_done.
REQ-016 The block SHALL have port o_busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-017 The state machine SHALL have the states IDLE, SEND and GAP.
REQ-018 In IDLE with i_en=1 and any i_req bit set, the block SHALL grant one requester, latch its frame into o_tx_frm, clear the retry count to 1 and the timer to 0, and enter SEND on the next edge.
REQ-019 Priority SHALL be: bit0 always wins; between bits 1 and 2 alone, round-robin with the last-granted of the two losing; the pointer SHALL reset so that bit1 wins first.
REQ-020 In SEND, o_tx_req SHALL be 1, o_tx_frm SHALL be held stable, and the timer SHALL increment each cycle.
REQ-021 In SEND, i_tx_done=1 with i_tx_nack=0 SHALL pulse o_req_ack[grant] on the next cycle and enter GAP.
REQ-022 In SEND, i_tx_done=1 with i_tx_nack=1, or the timer reaching TMO_CYC-1 without done, SHALL count as a failure.
REQ-023 On a failure with count < RETRY_MAX, the block SHALL increment the count, enter GAP, and return to SEND with the same frame and grant.
REQ-024 On a failure with count = RETRY_MAX, the block SHALL pulse o_req_err[grant] and enter GAP, then IDLE.
REQ-025 If i_tx_done and the timeout occur in the same cycle, done SHALL win.
REQ-026 In GAP, o_tx_req SHALL be 0 for exactly GAP_CYC cycles, after which the state SHALL be SEND on a pending retry and IDLE otherwise.
REQ-027 Requesters SHALL hold i_req until their ack or err pulse, and the block SHALL not re-grant the same requester in the cycle following its ack or err.
REQ-028 Deasserting i_en in SEND or GAP SHALL drop o_tx_req on the next cycle, abandon the grant without an ack or err pulse, and return to IDLE; an i_tx_done in that cycle SHALL be ignored.
REQ-029 i_tx_done outside SEND SHALL be ignored.
REQ-030 The round-robin pointer SHALL update only on a grant of bit1 or bit2.
REQ-031 At most one bit of o_req_ack | o_req_err SHALL be set in any cycle.

Reset
REQ-032 While i_rst_n=0, the block SHALL hold state IDLE, o_tx_req=0, o_tx_frm=0, o_req_ack=0, o_req_err=0, o_busy=0, the timer and count at 0, and the pointer preferring bit1.
REQ-033 A reset asserted mid-SEND SHALL drop o_tx_req asynchronously with no pending pulses after release.

Verification
REQ-034 i_en=1 with i_req=3'b110, then 3'b110 again -> first grant bit1, second grant bit2, each followed by a GAP of 4 cycles.
REQ-035 i_req=3'b111 -> bit0 granted first; o_tx_frm = frame0 held until done; o_req_ack=3'b001.
REQ-036 Engine never asserts done -> 3 SEND windows of 255 cycles each separated by 4-cycle gaps, then o_req_err[k] pulses once and the block returns to IDLE.
REQ-037 done with nack on the first attempt and done with ack on the second -> a single o_req_ack pulse and no err pulse.
REQ-038 i_en dropped in the 10th SEND cycle -> o_tx_req=0 on the next cycle, no pulses, IDLE; a later done is ignored.
REQ-039 Timeout cycle coincident with done and ack -> o_req_ack pulses and the retry count is not incremented.

Source files
------------

// File: rtl/lv_owt_tx_arb.sv
// OWT transmit arbiter: grants one of three requesters to the OWT tx engine,
// handles per-grant retries on nack/timeout and enforces an inter-frame gap.
module lv_owt_tx_arb #(
  parameter int FRM_W     = 16,
  parameter int TMO_CYC   = 255,
  parameter int RETRY_MAX = 3,
  parameter int GAP_CYC   = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [2:0]         i_req,
  input  logic [3*FRM_W-1:0] i_req_frm,
  output logic [2:0]         o_req_ack,
  output logic [2:0]         o_req_err,
  output logic               o_tx_req,
  output logic [FRM_W-1:0]   o_tx_frm,
  input  logic               i_tx_done,
  input  logic               i_tx_nack,
  output logic               o_busy
);

  localparam int              CNT_W    = (RETRY_MAX < 2) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RETRY_MAX);
  localparam logic [7:0]      TMO_LAST = 8'(TMO_CYC - 1);
  localparam logic [7:0]      GAP_LAST = 8'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t           state, state_d;
  logic [7:0]       timer, timer_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       grant, grant_d;
  logic [FRM_W-1:0] frm_d;
  logic             ptr, ptr_d;       // 1: bit2 preferred over bit1
  logic             retry, retry_d;   // GAP returns to SEND when set
  logic [2:0]       ack_d, err_d;
  logic [2:0]       elig;
  logic [2:0]       pick;
  logic [FRM_W-1:0] pick_frm;
  logic             fail;

  // Requester selection: bit0 fixed priority, bits 1/2 round-robin.
  always_comb begin
    elig = i_req & ~(o_req_ack | o_req_err);
    pick = '0;
    if (elig[0])                  pick = 3'b001;
    else if (elig[1] && elig[2])  pick = ptr ? 3'b100 : 3'b010;
    else if (elig[1])             pick = 3'b010;
    else if (elig[2])             pick = 3'b100;
    pick_frm = '0;
    if (pick[0])      pick_frm = i_req_frm[0 +: FRM_W];
    else if (pick[1]) pick_frm = i_req_frm[FRM_W +: FRM_W];
    else if (pick[2]) pick_frm = i_req_frm[2*FRM_W +: FRM_W];
  end

  // Next-state and next-datapath logic for the IDLE/SEND/GAP sequencer.
  always_comb begin
    state_d = state;
    timer_d = timer;
    cnt_d   = cnt;
    grant_d = grant;
    frm_d   = o_tx_frm;
    ptr_d   = ptr;
    retry_d = retry;
    ack_d   = '0;
    err_d   = '0;
    fail    = i_tx_done || (timer == TMO_LAST);
    unique case (state)
      IDLE: begin
        if (i_en && (pick != 3'b000)) begin
          grant_d = pick;
          frm_d   = pick_frm;
          cnt_d   = CNT_W'(1);
          timer_d = '0;
          state_d = SEND;
          if (!pick[0]) ptr_d = pick[1];
        end
      end
      SEND: begin
        if (!i_en) begin
          state_d = IDLE;
          timer_d = '0;
          retry_d = 1'b0;
        end else if (i_tx_done && !i_tx_nack) begin
          // done takes precedence over a coincident timeout
          ack_d   = grant;
          state_d = GAP;
          timer_d = '0;
          retry_d = 1'b0;
        end else if (fail) begin
          state_d = GAP;
          timer_d = '0;
          if (cnt == CNT_MAX) begin
            err_d   = grant;
            retry_d = 1'b0;
          end else begin
            cnt_d   = cnt + 1'b1;
            retry_d = 1'b1;
          end
        end else begin
          timer_d = timer + 8'd1;
        end
      end
      GAP: begin
        if (!i_en) begin
          state_d = IDLE;
          timer_d = '0;
          retry_d = 1'b0;
        end else if (timer == GAP_LAST) begin
          timer_d = '0;
          retry_d = 1'b0;
          state_d = retry ? SEND : IDLE;
        end else begin
          timer_d = timer + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      cnt       <= '0;
      grant     <= '0;
      o_tx_frm  <= '0;
      ptr       <= 1'b0;
      retry     <= 1'b0;
      o_req_ack <= '0;
      o_req_err <= '0;
    end else begin
      state     <= state_d;
      timer     <= timer_d;
      cnt       <= cnt_d;
      grant     <= grant_d;
      o_tx_frm  <= frm_d;
      ptr       <= ptr_d;
      retry     <= retry_d;
      o_req_ack <= ack_d;
      o_req_err <= err_d;
    end
  end

  assign o_tx_req = (state == SEND);
  assign o_busy   = (state != IDLE);

endmodule

// File: tb/tb_lv_owt_tx_arb.sv
// Self-checking bench for lv_owt_tx_arb: vector table, directed multi-cycle
// sequences and randomized traffic against a countdown-based reference model.
module tb_lv_owt_tx_arb;

  localparam int FRM_W     = 16;
  localparam int TMO_CYC   = 255;
  localparam int RETRY_MAX = 3;
  localparam int GAP_CYC   = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic [2:0]          req = '0;
  logic [FRM_W-1:0]    frm [3];
  logic                done = 1'b0;
  logic                nack = 1'b0;
  logic [3*FRM_W-1:0]  req_frm;
  logic [2:0]          req_ack;
  logic [2:0]          req_err;
  logic                tx_req;
  logic [FRM_W-1:0]    tx_frm;
  logic                busy;

  assign req_frm = {frm[2], frm[1], frm[0]};

  always #5 clk = ~clk;

  lv_owt_tx_arb #(
    .FRM_W(FRM_W),
    .TMO_CYC(TMO_CYC),
    .RETRY_MAX(RETRY_MAX),
    .GAP_CYC(GAP_CYC)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_en(en),
    .i_req(req),
    .i_req_frm(req_frm),
    .o_req_ack(req_ack),
    .o_req_err(req_err),
    .o_tx_req(tx_req),
    .o_tx_frm(tx_frm),
    .i_tx_done(done),
    .i_tx_nack(nack),
    .o_busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int ack_cnt = 0;
  logic [2:0] err_seen = '0;

  // Reference model: busy/sending flags with countdowns for window and gap.
  bit               m_busy, m_send, m_resend, m_pref2;
  int               m_win, m_gap, m_tries, m_who;
  logic [FRM_W-1:0] m_frm;
  logic [2:0]       m_ack, m_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_busy = 0; m_send = 0; m_resend = 0; m_pref2 = 0;
    m_win = 0; m_gap = 0; m_tries = 0; m_who = 0;
    m_frm = '0; m_ack = '0; m_err = '0;
  endfunction

  function automatic void model_step();
    logic [2:0] prev;
    logic [2:0] elig;
    prev  = m_ack | m_err;
    m_ack = '0;
    m_err = '0;
    if (!m_busy) begin
      elig = req & ~prev;
      if (en && elig != 3'b000) begin
        if (elig[0])                 m_who = 0;
        else if (elig[1] && elig[2]) m_who = m_pref2 ? 2 : 1;
        else                         m_who = elig[1] ? 1 : 2;
        if (m_who != 0) m_pref2 = (m_who == 1);
        m_frm = frm[m_who];
        m_tries = 1;
        m_busy = 1;
        m_send = 1;
        m_win = TMO_CYC;
      end
    end else if (!en) begin
      m_busy = 0;
      m_send = 0;
    end else if (m_send) begin
      if (done && !nack) begin
        m_ack[m_who] = 1'b1;
        m_send = 0; m_resend = 0; m_gap = GAP_CYC;
      end else if (done || m_win == 1) begin
        m_send = 0; m_gap = GAP_CYC;
        if (m_tries >= RETRY_MAX) begin
          m_err[m_who] = 1'b1;
          m_resend = 0;
        end else begin
          m_tries++;
          m_resend = 1;
        end
      end else begin
        m_win--;
      end
    end else begin
      m_gap--;
      if (m_gap == 0) begin
        if (m_resend) begin
          m_send = 1;
          m_win = TMO_CYC;
        end else begin
          m_busy = 0;
        end
      end
    end
  endfunction

  task automatic compare_model();
    chk("model_tx_req", 64'(tx_req), 64'(m_send));
    chk("model_busy", 64'(busy), 64'(m_busy));
    chk("model_frm", 64'(tx_frm), 64'(m_frm));
    chk("model_ack", 64'(req_ack), 64'(m_ack));
    chk("model_err", 64'(req_err), 64'(m_err));
    chk("pulse_onehot", 64'($countones(req_ack | req_err) <= 1), 64'd1);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (req_ack != 3'b000) ack_cnt++;
    err_seen = err_seen | req_err;
    compare_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; req = '0; done = 1'b0; nack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_tx_req", 64'(tx_req), 64'd0);
    chk("rst_frm", 64'(tx_frm), 64'd0);
    chk("rst_ack", 64'(req_ack), 64'd0);
    chk("rst_err", 64'(req_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    ack_cnt = 0;
    err_seen = '0;
  endtask

  task automatic count_tx(output int n);
    n = 0;
    while (tx_req && n < 2000) begin
      n++;
      step();
    end
  endtask

  task automatic count_gap(output int n);
    n = 0;
    while (busy && !tx_req && n < 100) begin
      n++;
      step();
    end
  endtask

  typedef struct {
    logic       en;
    logic [2:0] req;
    logic       exp_tx;
    logic       exp_busy;
    int         exp_idx;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int n;
    logic [FRM_W-1:0] expf;
    logic [FRM_W-1:0] f0, f1, f2;
    bit quiet;

    f0 = 16'hA0A0; f1 = 16'hB1B1; f2 = 16'hC2C2;
    frm[0] = f0; frm[1] = f1; frm[2] = f2;
    vecs[0] = '{1'b1, 3'b001, 1'b1, 1'b1, 0};
    vecs[1] = '{1'b1, 3'b010, 1'b1, 1'b1, 1};
    vecs[2] = '{1'b1, 3'b100, 1'b1, 1'b1, 2};
    vecs[3] = '{1'b1, 3'b011, 1'b1, 1'b1, 0};
    vecs[4] = '{1'b1, 3'b101, 1'b1, 1'b1, 0};
    vecs[5] = '{1'b1, 3'b110, 1'b1, 1'b1, 1};
    vecs[6] = '{1'b1, 3'b111, 1'b1, 1'b1, 0};
    vecs[7] = '{1'b0, 3'b111, 1'b0, 1'b0, -1};

    // Grant table from reset
    for (int i = 0; i < 8; i++) begin
      do_reset();
      en = vecs[i].en;
      req = vecs[i].req;
      step();
      chk($sformatf("vec%0d_tx_req", i), 64'(tx_req), 64'(vecs[i].exp_tx));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
      if (vecs[i].exp_idx < 0) expf = '0;
      else expf = frm[vecs[i].exp_idx];
      chk($sformatf("vec%0d_frm", i), 64'(tx_frm), 64'(expf));
    end

    // Round-robin between bits 1 and 2 with gaps
    do_reset();
    en = 1'b1; req = 3'b110;
    step();
    chk("rr_frm1", 64'(tx_frm), 64'(f1));
    repeat (3) step();
    done = 1'b1; step(); done = 1'b0;
    chk("rr_ack1", 64'(req_ack), 64'(3'b010));
    count_gap(n);
    chk("rr_gap1", 64'(n), 64'(GAP_CYC));
    chk("rr_idle1", 64'(busy), 64'd0);
    step();
    chk("rr_tx2", 64'(tx_req), 64'd1);
    chk("rr_frm2", 64'(tx_frm), 64'(f2));
    done = 1'b1; step(); done = 1'b0;
    chk("rr_ack2", 64'(req_ack), 64'(3'b100));
    req = 3'b000;
    count_gap(n);
    chk("rr_gap2", 64'(n), 64'(GAP_CYC));

    // bit0 wins over all, frame held until done
    do_reset();
    en = 1'b1; req = 3'b111;
    step();
    chk("p0_frm", 64'(tx_frm), 64'(f0));
    for (int i = 0; i < 5; i++) begin
      frm[0] = f0 ^ 16'(i + 1);
      step();
      chk("p0_frm_hold", 64'(tx_frm), 64'(f0));
    end
    frm[0] = f0;
    done = 1'b1; step(); done = 1'b0;
    chk("p0_ack", 64'(req_ack), 64'(3'b001));

    // Silent engine: three full windows then err
    do_reset();
    en = 1'b1; req = 3'b010;
    step();
    for (int w = 0; w < RETRY_MAX; w++) begin
      count_tx(n);
      chk($sformatf("tmo_win%0d", w), 64'(n), 64'(TMO_CYC));
      chk($sformatf("tmo_err%0d", w), 64'(req_err),
          64'((w == RETRY_MAX - 1) ? 3'b010 : 3'b000));
      chk($sformatf("tmo_ack%0d", w), 64'(req_ack), 64'd0);
      if (w == RETRY_MAX - 1) req = 3'b000;
      count_gap(n);
      chk($sformatf("tmo_gap%0d", w), 64'(n), 64'(GAP_CYC));
    end
    chk("tmo_idle", 64'(busy), 64'd0);
    chk("tmo_err_once", 64'(err_seen), 64'(3'b010));

    // nack then ack
    do_reset();
    en = 1'b1; req = 3'b100;
    step();
    repeat (3) step();
    done = 1'b1; nack = 1'b1; step(); done = 1'b0; nack = 1'b0;
    chk("nk_tx_low", 64'(tx_req), 64'd0);
    count_gap(n);
    chk("nk_gap", 64'(n), 64'(GAP_CYC));
    chk("nk_resend", 64'(tx_req), 64'd1);
    chk("nk_frm", 64'(tx_frm), 64'(f2));
    repeat (2) step();
    done = 1'b1; step(); done = 1'b0;
    chk("nk_ack", 64'(req_ack), 64'(3'b100));
    req = 3'b000;
    count_gap(n);
    chk("nk_ack_cnt", 64'(ack_cnt), 64'd1);
    chk("nk_no_err", 64'(err_seen), 64'd0);

    // Enable dropped in the 10th SEND cycle, then later done ignored
    do_reset();
    en = 1'b1; req = 3'b001;
    step();
    repeat (9) step();
    chk("en_tx_before", 64'(tx_req), 64'd1);
    en = 1'b0; done = 1'b1;
    step();
    done = 1'b0;
    chk("en_tx_drop", 64'(tx_req), 64'd0);
    chk("en_idle", 64'(busy), 64'd0);
    repeat (3) step();
    done = 1'b1; step(); done = 1'b0;
    repeat (2) step();
    chk("en_no_ack", 64'(ack_cnt), 64'd0);
    chk("en_no_err", 64'(err_seen), 64'd0);
    chk("en_still_idle", 64'(busy), 64'd0);

    // Asynchronous reset mid-SEND
    en = 1'b1;
    step();
    repeat (5) step();
    chk("ar_tx_before", 64'(tx_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_tx_async", 64'(tx_req), 64'd0);
    chk("ar_busy_async", 64'(busy), 64'd0);
    do_reset();
    en = 1'b1;
    repeat (4) step();
    chk("ar_no_pulse", 64'(ack_cnt) + 64'(err_seen), 64'd0);

    // done coincident with the timeout cycle
    do_reset();
    en = 1'b1; req = 3'b010;
    step();
    repeat (TMO_CYC - 1) step();
    chk("co_tx_last", 64'(tx_req), 64'd1);
    done = 1'b1; step(); done = 1'b0;
    chk("co_ack", 64'(req_ack), 64'(3'b010));
    chk("co_err", 64'(req_err), 64'd0);
    req = 3'b000;
    count_gap(n);
    chk("co_gap", 64'(n), 64'(GAP_CYC));
    step();
    chk("co_no_retry", 64'(tx_req), 64'd0);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      quiet = (c >= 1500 && c < 2600);
      en = quiet ? 1'b1 : ($urandom_range(0, 59) != 0);
      done = 1'b0; nack = 1'b0;
      if (tx_req && !quiet && $urandom_range(0, 5) == 0) begin
        done = 1'b1;
        nack = ($urandom_range(0, 2) == 0);
      end else if (!tx_req && $urandom_range(0, 29) == 0) begin
        done = 1'b1;
        nack = 1'($urandom_range(0, 1));
      end
      for (int k = 0; k < 3; k++) begin
        if (req[k] && (m_ack[k] || m_err[k])) begin
          req[k] = 1'b0;
        end else if (!req[k] && $urandom_range(0, 7) == 0) begin
          frm[k] = 16'($urandom);
          req[k] = 1'b1;
        end
      end
      step();
    end
    done = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
